// File: rtl/gp_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gp_sram_ctrl
// Description : Request-to-SRAM bridge for the gp_engine AHB slave.
//               Requests are queued in a small in-order FIFO. Each request
//               is issued to a synchronous single-port SRAM with a fixed
//               read latency. Read data goes back to the slave as a
//               one-cycle pulse. Accesses outside the SRAM are flagged on
//               o_err and never reach the SRAM. Reads that are out of range
//               still complete, returning zero, so the bus cannot hang.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk_ahb    in   1           clock
//   i_rstn_ahb   in   1           asynchronous active-low reset
//   i_valid      in   1           request valid
//   i_rd0_wr1    in   1           request type (0 read, 1 write)
//   i_addr       in   ADDR_WIDTH  byte address
//   i_wr_data    in   DATA_WIDTH  write data
//   o_ready      out  1           request accept (FIFO not full)
//   o_rd_valid   out  1           read-data pulse
//   o_rd_data    out  DATA_WIDTH  read data, held between pulses
//   o_mem_cs     out  1           SRAM chip select
//   o_mem_we     out  1           SRAM write enable
//   o_mem_addr   out  MEM_AW      SRAM word address
//   o_mem_wdata  out  DATA_WIDTH  SRAM write data
//   i_mem_rdata  in   DATA_WIDTH  SRAM read data (RD_LAT after read cs)
//   o_err        out  1           out-of-range pulse in the issue cycle
//   o_busy       out  1           FIFO non-empty or read outstanding
// ============================================================================
module gp_sram_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_AW     = 10,
  parameter int FIFO_DEPTH = 2,
  parameter int RD_LAT     = 1
) (
  input  logic                  i_clk_ahb,
  input  logic                  i_rstn_ahb,
  input  logic                  i_valid,
  input  logic                  i_rd0_wr1,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_ready,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_mem_cs,
  output logic                  o_mem_we,
  output logic [MEM_AW-1:0]     o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_err,
  output logic                  o_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(RD_LAT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LAT_LOAD = LW'(RD_LAT);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_RD_WAIT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Request FIFO
  // --------------------------------------------------------------------------
  logic                  fifo_wr_q   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;

  logic                  push;
  logic                  pop;
  logic                  head_wr;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_oor;
  logic                  addr_lsb_unused;

  // Ready comes only from the registered count, so a pop in the same cycle
  // never opens a slot early.
  assign o_ready = (count_q != FULL_CNT);
  assign push    = i_valid && o_ready;

  assign head_wr   = fifo_wr_q[rd_ptr_q];
  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  // Byte offset within a word has no meaning to the SRAM.
  assign addr_lsb_unused = ^head_addr[1:0];

  generate
    if (ADDR_WIDTH > MEM_AW + 2) begin : g_oor_chk
      assign head_oor = |head_addr[ADDR_WIDTH-1:MEM_AW+2];
    end else begin : g_no_oor_chk
      assign head_oor = 1'b0;
    end
  endgenerate

  always_ff @(posedge i_clk_ahb) begin
    if (push) begin
      fifo_wr_q[wr_ptr_q]   <= i_rd0_wr1;
      fifo_addr_q[wr_ptr_q] <= i_addr;
      fifo_data_q[wr_ptr_q] <= i_wr_data;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Issue / read-wait FSM
  // --------------------------------------------------------------------------
  state_t                state_q, state_d;
  logic [LW-1:0]         lat_q, lat_d;
  logic                  rd_oor_q, rd_oor_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [MEM_AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_cs;
  logic                  err;

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    rd_oor_d    = rd_oor_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pop         = 1'b0;
    mem_cs      = 1'b0;
    err         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop    = 1'b1;
          mem_cs = !head_oor;
          err    = head_oor;
          // SRAM address/data pins only move on a real access and hold
          // otherwise, so the _d value doubles as the pin value.
          if (!head_oor) begin
            mem_addr_d  = head_addr[MEM_AW+1:2];
            mem_wdata_d = head_data;
          end
          if (!head_wr) begin
            state_d  = S_RD_WAIT;
            lat_d    = LAT_LOAD;
            rd_oor_d = head_oor;
          end
        end
      end
      S_RD_WAIT: begin
        if (lat_q == LW'(1)) begin
          rd_valid_d = 1'b1;
          // An out-of-range read never touched the SRAM; return zero.
          rd_data_d  = rd_oor_q ? '0 : i_mem_rdata;
          state_d    = S_IDLE;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      state_q     <= S_IDLE;
      lat_q       <= '0;
      rd_oor_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      rd_oor_q    <= rd_oor_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign o_mem_cs    = mem_cs;
  assign o_mem_we    = mem_cs && head_wr;
  assign o_mem_addr  = mem_addr_d;
  assign o_mem_wdata = mem_wdata_d;
  assign o_err       = err;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = rd_data_q;
  assign o_busy      = (count_q != '0) || (state_q == S_RD_WAIT);

endmodule
`default_nettype wire
